// File: rtl/rv32i_memtop.sv
// RV32I memory stage: drives the data-memory bus for loads/stores and passes other results through.
// Optional: define MISALIGN_TRAP_EN to reject misaligned half/word accesses with a misalign pulse.
module rv32i_memtop #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] wb_data,
    output logic        bus_err,
    output logic        misalign
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lane_q, lane_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             valid_q, valid_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      iw_q, iw_d;
    logic [31:0]      wb_q, wb_d;
    logic             berr_q, berr_d;
    logic             mis_q, mis_d;

    logic [2:0]       f3_c;
    logic [1:0]       a_c;
    logic             is_mem_c;
    logic             f3_ok_c;
    logic             misalign_c;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [1:0]       lane_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [31:0]      load_c;

    // Decode the incoming instruction into bus lanes and legality.
    always_comb begin : decode
        f3_c       = iw_in[14:12];
        a_c        = alu_in[1:0];
        is_mem_c   = (iw_in[6:0] == OP_LOAD) || (iw_in[6:0] == OP_STORE);
        f3_ok_c    = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = rs2_data_in;
        lane_c     = 2'b00;
        misalign_c = 1'b0;
        case (f3_c)
            3'b000, 3'b001, 3'b010: f3_ok_c = is_mem_c;
            3'b100, 3'b101:         f3_ok_c = (iw_in[6:0] == OP_LOAD);
            default:                f3_ok_c = 1'b0;
        endcase
        case (f3_c[1:0])
            2'b00: begin
                be_c    = 4'b0001 << a_c;
                wdata_c = {4{rs2_data_in[7:0]}};
                lane_c  = a_c;
            end
            2'b01: begin
                be_c    = 4'b0011 << {a_c[1], 1'b0};
                wdata_c = {2{rs2_data_in[15:0]}};
                lane_c  = {a_c[1], 1'b0};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = rs2_data_in;
                lane_c  = 2'b00;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign_c = f3_ok_c && (((f3_c[1:0] == 2'b01) && a_c[0]) ||
                                 ((f3_c[1:0] == 2'b10) && (a_c != 2'b00)));
`else
        misalign_c = 1'b0;
`endif
    end

    // Align and extend returned load data using the lane captured at issue.
    always_comb begin : load_align
        byte_c = dmem_rdata[{lane_q, 3'b000} +: 8];
        half_c = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b100:  load_c = {24'b0, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b101:  load_c = {16'b0, half_c};
            default: load_c = dmem_rdata;
        endcase
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        valid_d = 1'b0;
        pc_d    = pc_q;
        iw_d    = iw_q;
        wb_d    = wb_q;
        berr_d  = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    pc_d = pc_in;
                    iw_d = iw_in;
                    if (is_mem_c && f3_ok_c && !misalign_c) begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                        f3_d    = f3_c;
                        lane_d  = lane_c;
                        req_d   = 1'b1;
                        we_d    = (iw_in[6:0] == OP_STORE);
                        addr_d  = {alu_in[31:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wdata_c;
                    end else begin
                        // Pass-through, undefined func3 and trapped accesses finish in one cycle.
                        valid_d = 1'b1;
                        wb_d    = is_mem_c ? 32'h0 : alu_in;
                        mis_d   = misalign_c;
                    end
                end
            end
            S_ACCESS: begin
                if (dmem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    valid_d = 1'b1;
                    wb_d    = we_q ? 32'h0 : load_c;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    valid_d = 1'b1;
                    berr_d  = 1'b1;
                    wb_d    = 32'h0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            iw_q    <= '0;
            wb_q    <= '0;
            berr_q  <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            iw_q    <= iw_d;
            wb_q    <= wb_d;
            berr_q  <= berr_d;
            mis_q   <= mis_d;
        end
    end

    assign stall      = (state_q == S_ACCESS);
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = wdata_q;
    assign valid_out  = valid_q;
    assign pc_out     = pc_q;
    assign iw_out     = iw_q;
    assign wb_data    = wb_q;
    assign bus_err    = berr_q;
    assign misalign   = mis_q;

endmodule

// File: doc/rv32i_memtop.md
Name: rv32i_memTop

Overview:
Memory stage of the RV32I pipeline. It sits directly after the execute stage and consumes that stage's registered ALU result: the effective address for loads and stores, or a final result for everything else.
- Loads and stores drive a data-memory request/acknowledge bus with byte enables; load data is aligned and sign- or zero-extended for writeback.
- All other instructions pass through with one cycle of latency.
- The stage stalls upstream while a bus access is outstanding.

Parameters:
- TIMEOUT, 64, cycles to wait in ACCESS for dmem_ack before aborting with bus_err.

Ports:
- clk  in  1  system clock, single clock domain
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  execute-stage result valid this cycle
- pc_in  in  32  PC of the instruction
- iw_in  in  32  instruction word
- alu_in  in  32  execute-stage result; effective address for loads and stores
- rs2_data_in  in  32  store data
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  word address, {addr[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle
- dmem_rdata  in  32  read data
- stall  out  1  upstream must hold its outputs and must not advance
- valid_out  out  1  one-cycle pulse: result ready for writeback
- pc_out  out  32  PC of the completing instruction
- iw_out  out  32  instruction word of the completing instruction
- wb_data  out  32  writeback value
- bus_err  out  1  one-cycle pulse on bus timeout
- misalign  out  1  one-cycle pulse on misaligned access; tied to 0 unless MISALIGN_TRAP_EN is defined

Behaviour:
Clock and reset
- One clock, clk. reset is synchronous and active-high.
- On reset: state = IDLE; every output = 0 (dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall, valid_out, pc_out, iw_out, wb_data, bus_err, misalign).
- Reset mid-access: dmem_req is low in the cycle after reset is sampled; any later dmem_ack is ignored; no valid_out is produced for the aborted instruction.

States
- IDLE: accepts valid_in.
- ACCESS: dmem_req = 1.

Non-memory instructions (opcode is neither 0000011 nor 0100011)
- valid_in in IDLE: next cycle valid_out = 1, wb_data = alu_in, and pc_out/iw_out are copied from the inputs.
- Latency is 1 cycle.

Memory instructions
- valid_in with opcode 0000011 (load) or 0100011 (store), in IDLE: latch pc, iw, address and store data; state <= ACCESS.
- In ACCESS: dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and held stable until ack.
- stall = (state == ACCESS), combinational.
- dmem_ack sampled in ACCESS: state <= IDLE; next cycle valid_out = 1.
- Minimum latency from valid_in to valid_out is 2 cycles, reached when ack arrives in the first ACCESS cycle.
- Inputs are ignored while stall = 1. dmem_ack outside ACCESS is ignored.

Byte lanes (a = addr[1:0])
- Byte (func3 000/100): be = 4'b0001 << a; wdata = {4{rs2[7:0]}}.
- Half (func3 001/101): be = 4'b0011 << {a[1], 1'b0}; wdata = {2{rs2[15:0]}}.
- Word (func3 010): be = 4'b1111; wdata = rs2.

Load result
- Extracted field = dmem_rdata >> (8 * lane), where lane is a for bytes and {a[1], 0} for halves.
- LB and LH sign-extend; LBU and LHU zero-extend; LW takes the full word.

Stores and invalid func3
- Stores complete with wb_data = 0.
- Load or store with an undefined func3: no bus access; valid_out is produced after 1 cycle with wb_data = 0.

Timeout
- Counter is cleared on entry to ACCESS.
- If TIMEOUT cycles pass without ack: dmem_req drops, bus_err and valid_out pulse together, wb_data = 0, state <= IDLE.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, makes no bus access. misalign and valid_out pulse together 1 cycle after valid_in, with wb_data = 0 and stall never asserted.
- Undefined: low address bits are ignored per the lane rules above, and misalign is tied to 0.

Test Plan:
- ADD passthrough: valid_in, alu_in = 0x0000_1234 -> next cycle valid_out = 1, wb_data = 0x1234, stall = 0 throughout.
- LB, addr 0x103, ack in first ACCESS cycle with rdata = 0x80FF_FFFF -> dmem_addr = 0x100, be = 1000, wb_data = 0xFFFF_FF80; LBU on the same access -> 0x0000_0080; valid_out 2 cycles after valid_in.
- SH, addr 0x202, rs2 = 0xAAAA_BEEF, ack delayed 3 cycles -> dmem_we = 1, be = 1100, wdata = 0xBEEF_BEEF held stable, stall high for 4 cycles, then valid_out with wb_data = 0.
- LW with no ack -> after 64 ACCESS cycles dmem_req = 0, bus_err and valid_out pulse, wb_data = 0, the next instruction is accepted.
- reset asserted in the 2nd ACCESS cycle, ack arrives the following cycle -> all outputs 0, no valid_out, state IDLE.
- MISALIGN_TRAP_EN defined, LW addr 0x302 -> no dmem_req, misalign = 1 and valid_out = 1 one cycle later; undefined -> word access to 0x300 with be = 1111.
